ucie_ctl_sb_tx_arbiter: RTL and testbench
=========================================

Name: ucie_ctl_sb_tx_arbiter

Overview:
Shares the single adapter sideband transmit channel between the adapter's internal message sources: parameter negotiation, the active handshake and the linkreset handshake. It sits between the CNTL FSM/negotiation logic and the PHY sideband TX interface. It arbitrates requests, holds each granted message until the PHY accepts it, and enforces a minimum inter-message gap. It times out stuck transfers and supports an abort on LINKERROR.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 1024, cycles a message may wait for i_sb_ready before being dropped (>=2)
GAP_CYCLES, 2, idle cycles enforced after each completed or dropped message (>=1)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  N_REQ  per-requester request, level, held until ack/drop
i_req_msg  in  5*N_REQ  per-requester e_SB_msg code; slice k = [5k+4:5k]; stable while valid
o_req_ack  out  N_REQ  one-cycle pulse: requester k's message accepted by PHY
o_req_drop  out  N_REQ  one-cycle pulse: requester k's message timed out
o_sb_valid  out  1  sideband TX valid to PHY
o_sb_msg  out  5  sideband TX message code
i_sb_ready  in  1  PHY accepts message when high with o_sb_valid
i_flush  in  1  abort: LINKERROR entry, synchronous
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async, i_rst_n low): state IDLE, o_sb_valid 0, o_sb_msg 5'b00000, o_req_ack 0, o_req_drop 0, o_busy 0, rr pointer 0, timeout/gap counters 0, grant index 0.
- States: IDLE, SEND, GAP.
- IDLE: when any i_req_valid is high, select a winner, latch its index and msg, and go to SEND. o_sb_valid rises the next cycle, so request-to-valid latency is 1 cycle.
- Priority classes: response messages (msg[3]==1, i.e. SB_ADAPTER_RSP_ACTIVE 11001 and SB_ADAPTER_RSP_LINKRESET 11011) beat all others.
- Within a class, selection is round-robin: scan starts at the rr pointer and the first valid index wins. On grant, rr pointer = (winner+1) mod N_REQ.
- SEND: o_sb_valid=1 and o_sb_msg=latched msg, both held stable. The timeout counter increments every cycle.
  - i_sb_ready high: transfer completes at that edge. o_req_ack[winner] pulses the following cycle. Go to GAP.
  - Counter reaches TIMEOUT-1 with no ready: o_req_drop[winner] pulses the following cycle, o_sb_valid drops, go to GAP.
  - Ready wins if it arrives in the same cycle as the timeout.
- The message is latched. Deasserting i_req_valid[winner] during SEND does not cancel it; ack or drop still pulses.
- GAP: o_sb_valid=0 for exactly GAP_CYCLES cycles, then IDLE. No arbitration occurs in GAP, which gives requesters time to drop valid after ack/drop.
- i_flush (highest priority, any state): next cycle the state is IDLE, o_sb_valid=0 and the counters clear. No ack or drop pulses. The rr pointer is retained. While i_flush is high, no grant is issued.
- Simultaneous events:
  - Flush and ready in the same SEND cycle: flush wins and no ack is issued. The PHY is responsible for discarding the message.
  - Multiple responses valid: round-robin among them. Requests wait.
- Reset mid-SEND: o_sb_valid drops immediately (async). Nothing is acked.
- o_busy = (state != IDLE), registered with the state.
- At most one of o_req_ack/o_req_drop bits is high in any cycle.

Test Plan:
- Single request: N_REQ=4, k=1 raises valid with msg 10101, ready tied high -> o_sb_valid next cycle with o_sb_msg=10101. o_req_ack[1] pulses 1 cycle after accept. o_sb_valid stays 0 for 2 cycles.
- Response priority: same cycle, req0=10101 and req2=11001 -> 11001 sent first, then 10101 after the gap.
- Round-robin: all 4 requesters hold valid with msg 00000, ack each on its grant -> grant order 0,1,2,3,0 with a 2-cycle gap between each.
- Timeout: TIMEOUT=8, ready held low -> o_sb_valid high exactly 8 cycles, then o_req_drop[k] pulses, no ack, then GAP.
- Ready on the timeout cycle: ready asserted in the 8th SEND cycle -> ack pulses, not drop.
- Flush mid-SEND: i_flush pulsed in SEND cycle 3 with ready also high -> o_sb_valid=0 next cycle, state IDLE, no ack/drop. Async reset asserted mid-SEND -> all outputs 0 immediately.

Source files
------------

// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Sideband TX arbiter: shares the adapter sideband transmit channel between internal
// message sources, with response priority, round-robin fairness, timeout, gap and flush.
module ucie_ctl_sb_tx_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [5*N_REQ-1:0]   i_req_msg,
    output logic [N_REQ-1:0]     o_req_ack,
    output logic [N_REQ-1:0]     o_req_drop,
    output logic                 o_sb_valid,
    output logic [4:0]           o_sb_msg,
    input  logic                 i_sb_ready,
    input  logic                 i_flush,
    output logic                 o_busy
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    grant_idx;
    logic [TW-1:0]    to_cnt;
    logic [GW-1:0]    gap_cnt;

    logic [N_REQ-1:0] rsp_mask;
    logic [N_REQ-1:0] cand_mask;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [4:0]       win_msg;
    logic [IW-1:0]    rr_next;

    // Winner select: responses (msg[3]) first, then round-robin from rr_ptr with wrap.
    always_comb begin
        rsp_mask  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_msg   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rsp_mask[k] = i_req_valid[k] & i_req_msg[5*k+3];
        end
        cand_mask = (|rsp_mask) ? rsp_mask : i_req_valid;
        for (int j = 0; j < N_REQ; j++) begin
            if (!win_found && cand_mask[j] && (IW'(j) >= rr_ptr)) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
                win_msg   = i_req_msg[5*j +: 5];
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!win_found && cand_mask[j]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
                win_msg   = i_req_msg[5*j +: 5];
            end
        end
        rr_next = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
    end

    // Main FSM with registered outputs; flush overrides every state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            o_sb_valid <= 1'b0;
            o_sb_msg   <= '0;
            o_req_ack  <= '0;
            o_req_drop <= '0;
            o_busy     <= 1'b0;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
        end else begin
            o_req_ack  <= '0;
            o_req_drop <= '0;
            if (i_flush) begin
                state      <= ST_IDLE;
                o_sb_valid <= 1'b0;
                o_busy     <= 1'b0;
                to_cnt     <= '0;
                gap_cnt    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (win_found) begin
                            state      <= ST_SEND;
                            grant_idx  <= win_idx;
                            o_sb_msg   <= win_msg;
                            o_sb_valid <= 1'b1;
                            o_busy     <= 1'b1;
                            rr_ptr     <= rr_next;
                            to_cnt     <= '0;
                        end
                    end
                    ST_SEND: begin
                        // Ready takes precedence over a coincident timeout.
                        if (i_sb_ready) begin
                            o_req_ack  <= N_REQ'(1) << grant_idx;
                            o_sb_valid <= 1'b0;
                            state      <= ST_GAP;
                            to_cnt     <= '0;
                            gap_cnt    <= '0;
                        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                            o_req_drop <= N_REQ'(1) << grant_idx;
                            o_sb_valid <= 1'b0;
                            state      <= ST_GAP;
                            to_cnt     <= '0;
                            gap_cnt    <= '0;
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                            state   <= ST_IDLE;
                            o_busy  <= 1'b0;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        o_sb_valid <= 1'b0;
                        o_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ucie_ctl_sb_tx_arbiter.sv
// Directed self-checking bench for the sideband TX arbiter (N_REQ=4, TIMEOUT=8, GAP_CYCLES=2).
module tb_ucie_ctl_sb_tx_arbiter;

    localparam int unsigned N_REQ      = 4;
    localparam int unsigned TIMEOUT    = 8;
    localparam int unsigned GAP_CYCLES = 2;

    logic                clk;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [5*N_REQ-1:0]  req_msg;
    logic [N_REQ-1:0]    req_ack;
    logic [N_REQ-1:0]    req_drop;
    logic                sb_valid;
    logic [4:0]          sb_msg;
    logic                sb_ready;
    logic                flush;
    logic                busy;

    int checks = 0;
    int errors = 0;

    ucie_ctl_sb_tx_arbiter #(
        .N_REQ      (N_REQ),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_msg   (req_msg),
        .o_req_ack   (req_ack),
        .o_req_drop  (req_drop),
        .o_sb_valid  (sb_valid),
        .o_sb_msg    (sb_msg),
        .i_sb_ready  (sb_ready),
        .i_flush     (flush),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [4:0] m);
        req_valid[k]       = v;
        req_msg[5*k +: 5]  = m;
    endtask

    task automatic apply_reset;
        req_valid = '0;
        req_msg   = '0;
        sb_ready  = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        req_valid = '0;
        req_msg   = '0;
        sb_ready  = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        tick();
        checks++;
        if (sb_valid !== 1'b0 || sb_msg !== 5'b00000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b msg=%b busy=%b exp 0 00000 0", sb_valid, sb_msg, busy);
        end
        checks++;
        if (req_ack !== 4'b0000 || req_drop !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses got ack=%b drop=%b exp 0000 0000", req_ack, req_drop);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (sb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got valid=%b busy=%b exp 0 0", sb_valid, busy);
        end
    endtask

    task automatic test_single;
        set_req(1, 1'b1, 5'b10101);
        sb_ready = 1'b1;
        tick();
        checks++;
        if (sb_valid !== 1'b1 || sb_msg !== 5'b10101 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_send got valid=%b msg=%b busy=%b exp 1 10101 1", sb_valid, sb_msg, busy);
        end
        tick();
        checks++;
        if (req_ack !== 4'b0010 || req_drop !== 4'b0000 || sb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got ack=%b drop=%b valid=%b exp 0010 0000 0", req_ack, req_drop, sb_valid);
        end
        set_req(1, 1'b0, 5'b00000);
        tick();
        checks++;
        if (req_ack !== 4'b0000 || sb_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap2 got ack=%b valid=%b busy=%b exp 0000 0 1", req_ack, sb_valid, busy);
        end
        tick();
        checks++;
        if (sb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got valid=%b busy=%b exp 0 0", sb_valid, busy);
        end
        sb_ready = 1'b0;
    endtask

    task automatic test_rsp_priority;
        set_req(0, 1'b1, 5'b10101);
        set_req(2, 1'b1, 5'b11001);
        sb_ready = 1'b1;
        tick();
        checks++;
        if (sb_valid !== 1'b1 || sb_msg !== 5'b11001) begin
            errors++;
            $display("FAIL prio_first got valid=%b msg=%b exp 1 11001", sb_valid, sb_msg);
        end
        tick();
        checks++;
        if (req_ack !== 4'b0100) begin
            errors++;
            $display("FAIL prio_ack_rsp got ack=%b exp 0100", req_ack);
        end
        set_req(2, 1'b0, 5'b00000);
        tick();
        tick();
        checks++;
        if (sb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_gap got valid=%b busy=%b exp 0 0", sb_valid, busy);
        end
        tick();
        checks++;
        if (sb_valid !== 1'b1 || sb_msg !== 5'b10101) begin
            errors++;
            $display("FAIL prio_second got valid=%b msg=%b exp 1 10101", sb_valid, sb_msg);
        end
        tick();
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL prio_ack_req got ack=%b exp 0001", req_ack);
        end
        set_req(0, 1'b0, 5'b00000);
        sb_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_ack;
        apply_reset();
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 5'b00000);
        sb_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp_ack = 4'b0001 << (n % 4);
            tick();
            checks++;
            if (sb_valid !== 1'b1 || sb_msg !== 5'b00000) begin
                errors++;
                $display("FAIL rr_send%0d got valid=%b msg=%b exp 1 00000", n, sb_valid, sb_msg);
            end
            tick();
            checks++;
            if (req_ack !== exp_ack || sb_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_ack%0d got ack=%b valid=%b exp %b 0", n, req_ack, sb_valid, exp_ack);
            end
            tick();
            checks++;
            if (sb_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_gap%0d got valid=%b busy=%b exp 0 1", n, sb_valid, busy);
            end
            tick();
        end
        req_valid = '0;
        sb_ready  = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        apply_reset();
        set_req(3, 1'b1, 5'b00101);
        sb_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (sb_valid !== 1'b1 || req_drop !== 4'b0000 || req_ack !== 4'b0000) begin
                errors++;
                $display("FAIL to_hold%0d got valid=%b drop=%b ack=%b exp 1 0000 0000", c, sb_valid, req_drop, req_ack);
            end
        end
        tick();
        checks++;
        if (sb_valid !== 1'b0 || req_drop !== 4'b1000 || req_ack !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_drop got valid=%b drop=%b ack=%b busy=%b exp 0 1000 0000 1", sb_valid, req_drop, req_ack, busy);
        end
        set_req(3, 1'b0, 5'b00000);
        tick();
        checks++;
        if (req_drop !== 4'b0000 || sb_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_drop_once got drop=%b valid=%b exp 0000 0", req_drop, sb_valid);
        end
        tick();
    endtask

    task automatic test_ready_on_timeout;
        set_req(1, 1'b1, 5'b11011);
        sb_ready = 1'b0;
        tick();
        for (int c = 2; c <= 8; c++) tick();
        checks++;
        if (sb_valid !== 1'b1 || sb_msg !== 5'b11011) begin
            errors++;
            $display("FAIL rt_cycle8 got valid=%b msg=%b exp 1 11011", sb_valid, sb_msg);
        end
        sb_ready = 1'b1;
        tick();
        checks++;
        if (req_ack !== 4'b0010 || req_drop !== 4'b0000) begin
            errors++;
            $display("FAIL rt_ack got ack=%b drop=%b exp 0010 0000", req_ack, req_drop);
        end
        set_req(1, 1'b0, 5'b00000);
        sb_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_flush;
        set_req(0, 1'b1, 5'b10001);
        sb_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (sb_valid !== 1'b1 || sb_msg !== 5'b10001) begin
            errors++;
            $display("FAIL fl_send got valid=%b msg=%b exp 1 10001", sb_valid, sb_msg);
        end
        flush    = 1'b1;
        sb_ready = 1'b1;
        tick();
        checks++;
        if (sb_valid !== 1'b0 || busy !== 1'b0 || req_ack !== 4'b0000 || req_drop !== 4'b0000) begin
            errors++;
            $display("FAIL fl_abort got valid=%b busy=%b ack=%b drop=%b exp 0 0 0000 0000", sb_valid, busy, req_ack, req_drop);
        end
        sb_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (sb_valid !== 1'b0 || busy !== 1'b0 || req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL fl_hold got valid=%b busy=%b ack=%b exp 0 0 0000", sb_valid, busy, req_ack);
        end
        flush = 1'b0;
        tick();
        checks++;
        if (sb_valid !== 1'b1 || sb_msg !== 5'b10001) begin
            errors++;
            $display("FAIL fl_regrant got valid=%b msg=%b exp 1 10001", sb_valid, sb_msg);
        end
        sb_ready = 1'b1;
        tick();
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL fl_ack got ack=%b exp 0001", req_ack);
        end
        set_req(0, 1'b0, 5'b00000);
        sb_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_send;
        set_req(2, 1'b1, 5'b00111);
        tick();
        checks++;
        if (sb_valid !== 1'b1 || sb_msg !== 5'b00111) begin
            errors++;
            $display("FAIL rs_send got valid=%b msg=%b exp 1 00111", sb_valid, sb_msg);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sb_valid !== 1'b0 || busy !== 1'b0 || sb_msg !== 5'b00000 || req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL rs_async got valid=%b busy=%b msg=%b ack=%b exp 0 0 00000 0000", sb_valid, busy, sb_msg, req_ack);
        end
        set_req(2, 1'b0, 5'b00000);
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (sb_valid !== 1'b0 || req_ack !== 4'b0000 || req_drop !== 4'b0000) begin
            errors++;
            $display("FAIL rs_after got valid=%b ack=%b drop=%b exp 0 0000 0000", sb_valid, req_ack, req_drop);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rsp_priority();
        test_round_robin();
        test_timeout();
        test_ready_on_timeout();
        test_flush();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
